// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner.
// Segment patterns are active-low, with bits ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational converter from a hex nibble to active-low segments {g,f,e,d,c,b,a}.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode display, with a shadow value captured once per frame.
// Defining SEG7_LEADING_ZERO_BLANK_EN turns on leading-zero blanking for digits 3..1.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    digit_e        r_digit;
    logic [15:0]   r_shadow;
    logic [3:0]    r_shadow_dp;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_tick;

    logic          w_step;
    digit_e        w_next_digit;
    logic [15:0]   w_next_shadow;
    logic [3:0]    w_next_shadow_dp;
    logic          w_frame;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic          w_blank;
    logic [3:0]    w_an;

    assign w_step = enable && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit     <= DIG0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
        end else begin
            r_digit     <= w_next_digit;
            r_shadow    <= w_next_shadow;
            r_shadow_dp <= w_next_shadow_dp;
        end
    end

    // The shadow registers load only when DIG3 wraps back to DIG0, so a frame never mixes two values.
    always_comb begin
        w_next_digit     = r_digit;
        w_next_shadow    = r_shadow;
        w_next_shadow_dp = r_shadow_dp;
        w_frame          = 1'b0;
        if (w_step) begin
            case (r_digit)
                DIG0: w_next_digit = DIG1;
                DIG1: w_next_digit = DIG2;
                DIG2: w_next_digit = DIG3;
                DIG3: begin
                    w_next_digit     = DIG0;
                    w_next_shadow    = value_in;
                    w_next_shadow_dp = dp_in;
                    w_frame          = 1'b1;
                end
                default: w_next_digit = DIG0;
            endcase
        end
    end

    always_comb begin
        w_nibble = w_next_shadow[3:0];
        w_blank  = 1'b0;
        case (w_next_digit)
            DIG0: w_nibble = w_next_shadow[3:0];
            DIG1: w_nibble = w_next_shadow[7:4];
            DIG2: w_nibble = w_next_shadow[11:8];
            DIG3: w_nibble = w_next_shadow[15:12];
            default: w_nibble = w_next_shadow[3:0];
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (w_next_digit)
            DIG1: w_blank = (w_next_shadow[15:4] == 12'h000);
            DIG2: w_blank = (w_next_shadow[15:8] == 8'h00);
            DIG3: w_blank = (w_next_shadow[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    assign w_an = ~(4'b0001 << w_next_digit);

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= 4'b1111;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame;
            if (enable) begin
                r_an  <= w_an;
                r_seg <= w_blank ? SEG_BLANK : w_seg_dec;
                r_dp  <= ~w_next_shadow_dp[w_next_digit];
            end else begin
                r_an  <= 4'b1111;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner with DIGIT_PERIOD=4, so each frame lasts 16 clocks.
module tb_seg7_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [3:0][3:0] AN_TAB = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][6:0] S1234  = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [3:0][6:0] SABCD  = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [3:0][6:0] SZERO  = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
    localparam logic [3:0][6:0] S0050  = {7'h7F, 7'h7F, 7'b0010010, 7'b1000000};
`else
    localparam logic [3:0][6:0] SZERO  = {4{7'b1000000}};
    localparam logic [3:0][6:0] S0050  = {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000};
`endif

    seg7_scanner #(.DIGIT_PERIOD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic e_ft);
        n_vec++;
        assert (an === e_an) else begin
            n_err++; $error("FAIL %s an: got %b want %b", tag, an, e_an);
        end
        n_vec++;
        assert (seg === e_seg) else begin
            n_err++; $error("FAIL %s seg: got %b want %b", tag, seg, e_seg);
        end
        n_vec++;
        assert (dp === e_dp) else begin
            n_err++; $error("FAIL %s dp: got %b want %b", tag, dp, e_dp);
        end
        n_vec++;
        assert (frame_tick === e_ft) else begin
            n_err++; $error("FAIL %s frame_tick: got %b want %b", tag, frame_tick, e_ft);
        end
    endtask

    // Walks clocks 1..15 of a frame; the boundary clock is checked separately by the caller.
    task automatic run_frame(input string tag, input logic [3:0][6:0] segs, input logic [3:0] dpm,
                             input int chg_at, input logic [15:0] chg_val, input int pause_at);
        for (int i = 1; i <= 15; i++) begin
            int k;
            k = i / 4;
            tick();
            expect_out($sformatf("%s_c%0d", tag, i), AN_TAB[k], segs[k], ~dpm[k], 1'b0);
            if (i == chg_at) value_in = chg_val;
            if (i == pause_at) begin
                enable = 1'b0;
                for (int p = 0; p < 10; p++) begin
                    tick();
                    expect_out($sformatf("%s_off%0d", tag, p), 4'b1111, 7'h7F, 1'b1, 1'b0);
                end
                enable = 1'b1;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        value_in = 16'h1234;
        dp_in    = 4'b0000;
        enable   = 1'b1;
        @(negedge clk);
        expect_out("reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;

        run_frame("f1", SZERO, 4'b0000, 0, 16'h0000, 0);
        tick();
        expect_out("f2_start", 4'b1110, 7'b0011001, 1'b1, 1'b1);

        run_frame("f2", S1234, 4'b0000, 6, 16'hABCD, 0);
        tick();
        expect_out("f3_start", 4'b1110, 7'b0100001, 1'b1, 1'b1);

        dp_in = 4'b0100;
        run_frame("f3", SABCD, 4'b0000, 0, 16'h0000, 9);
        tick();
        expect_out("f4_start", 4'b1110, 7'b0100001, 1'b1, 1'b1);

        run_frame("f4", SABCD, 4'b0100, 15, 16'h5678, 0);
        tick();
        expect_out("f5_start", 4'b1110, 7'b0000000, 1'b1, 1'b1);

        #2;
        rst      = 1'b1;
        value_in = 16'h0050;
        dp_in    = 4'b0000;
        #1;
        expect_out("midrst", 4'b1111, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_frame("z1", SZERO, 4'b0000, 0, 16'h0000, 0);
        tick();
        expect_out("z2_start", 4'b1110, 7'b1000000, 1'b1, 1'b1);
        run_frame("z2", S0050, 4'b0000, 0, 16'h0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
